// File: rtl/instr_encoder_pkg.sv
// Shared encoder/decoder/executer definitions: memory and instruction widths,
// the STOP opcode and the encoder FSM state type.
package instr_encoder_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 8;
    localparam int unsigned INSTR_WIDTH    = 16;
    localparam int unsigned CNT_WIDTH      = 8;
    localparam int unsigned CNT_EXT_WIDTH  = CNT_WIDTH + 1;

    localparam logic [INSTR_WIDTH-1:0] INSTR_STOP = INSTR_WIDTH'(16'hFFFF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPT,
        ST_WRITE,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Moves instructions from an external sync FIFO into program memory, one
// batch of up to BATCH words per do_it request, stopping for good on STOP.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned BATCH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      do_it,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    output logic [MEM_ADDR_WIDTH-1:0] addr_out,
    output logic                      done,
    output logic                      stop,
    input  logic                      fifo_empty,
    output logic                      fifo_rd,
    input  logic [INSTR_WIDTH-1:0]    fifo_data,
    input  logic                      mem_busy,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [INSTR_WIDTH-1:0]    mem_wdata
);

    localparam logic [CNT_EXT_WIDTH-1:0] BATCH_LIMIT = CNT_EXT_WIDTH'(BATCH);

    enc_state_e                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic [INSTR_WIDTH-1:0]    word_q, word_d;
    logic                      stop_q, stop_d;
    logic                      done_q, done_d;
    logic                      last_of_batch;

    assign last_of_batch = (CNT_EXT_WIDTH'(count_q) + CNT_EXT_WIDTH'(1)) == BATCH_LIMIT;

    // Next-state and strobe logic; fifo_rd/mem_we react to same-cycle handshakes.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        addr_out_d = addr_out_q;
        count_d    = count_q;
        word_d     = word_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        fifo_rd    = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (do_it && !stop_q) begin
                    cur_addr_d = addr;
                    count_d    = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                word_d  = fifo_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!mem_busy) begin
                    mem_we     = 1'b1;
                    cur_addr_d = cur_addr_q + MEM_ADDR_WIDTH'(1);
                    count_d    = count_q + CNT_WIDTH'(1);
                    if (word_q == INSTR_STOP || last_of_batch) begin
                        stop_d     = stop_q | (word_q == INSTR_STOP);
                        done_d     = 1'b1;
                        addr_out_d = cur_addr_d;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            addr_out_q <= '0;
            count_q    <= '0;
            word_q     <= '0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            addr_out_q <= addr_out_d;
            count_q    <= count_d;
            word_q     <= word_d;
            stop_q     <= stop_d;
            done_q     <= done_d;
        end
    end

    assign addr_out  = addr_out_q;
    assign done      = done_q;
    assign stop      = stop_q;
    assign mem_addr  = cur_addr_q;
    assign mem_wdata = word_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: three instances (BATCH 4, 8, 3) share one
// FIFO/memory model, and sel picks which one is driven and observed.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset = 1'b1;
    logic                      do_it = 1'b0;
    logic                      mem_busy = 1'b0;
    logic [MEM_ADDR_WIDTH-1:0] addr = '0;
    logic [INSTR_WIDTH-1:0]    fifo_data = '0;
    logic                      fifo_empty;
    int                        sel = 0;

    logic                      rd_v [3];
    logic                      we_v [3];
    logic                      done_v [3];
    logic                      stop_v [3];
    logic [MEM_ADDR_WIDTH-1:0] ao_v [3];
    logic [MEM_ADDR_WIDTH-1:0] ma_v [3];
    logic [INSTR_WIDTH-1:0]    wd_v [3];

    instr_encoder #(.BATCH(4)) u_b4 (
        .clk(clk), .reset(reset), .do_it(do_it && (sel == 0)), .addr(addr),
        .addr_out(ao_v[0]), .done(done_v[0]), .stop(stop_v[0]),
        .fifo_empty(fifo_empty), .fifo_rd(rd_v[0]), .fifo_data(fifo_data),
        .mem_busy(mem_busy), .mem_we(we_v[0]), .mem_addr(ma_v[0]), .mem_wdata(wd_v[0])
    );
    instr_encoder #(.BATCH(8)) u_b8 (
        .clk(clk), .reset(reset), .do_it(do_it && (sel == 1)), .addr(addr),
        .addr_out(ao_v[1]), .done(done_v[1]), .stop(stop_v[1]),
        .fifo_empty(fifo_empty), .fifo_rd(rd_v[1]), .fifo_data(fifo_data),
        .mem_busy(mem_busy), .mem_we(we_v[1]), .mem_addr(ma_v[1]), .mem_wdata(wd_v[1])
    );
    instr_encoder #(.BATCH(3)) u_b3 (
        .clk(clk), .reset(reset), .do_it(do_it && (sel == 2)), .addr(addr),
        .addr_out(ao_v[2]), .done(done_v[2]), .stop(stop_v[2]),
        .fifo_empty(fifo_empty), .fifo_rd(rd_v[2]), .fifo_data(fifo_data),
        .mem_busy(mem_busy), .mem_we(we_v[2]), .mem_addr(ma_v[2]), .mem_wdata(wd_v[2])
    );

    logic                      rd_o, we_o, done_o, stop_o;
    logic [MEM_ADDR_WIDTH-1:0] ao_o, ma_o;
    logic [INSTR_WIDTH-1:0]    wd_o;
    assign rd_o   = rd_v[sel];
    assign we_o   = we_v[sel];
    assign done_o = done_v[sel];
    assign stop_o = stop_v[sel];
    assign ao_o   = ao_v[sel];
    assign ma_o   = ma_v[sel];
    assign wd_o   = wd_v[sel];

    // FIFO model with registered read data; skip_cnt discards leftovers on flush.
    logic [INSTR_WIDTH-1:0] fbuf [64];
    int push_cnt = 0;
    int pop_cnt  = 0;
    int skip_cnt = 0;
    assign fifo_empty = (push_cnt == pop_cnt + skip_cnt);

    always @(posedge clk) begin
        if (rd_o) begin
            fifo_data <= fbuf[pop_cnt + skip_cnt];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // Memory write log and event counters.
    logic [MEM_ADDR_WIDTH-1:0] wa  [64];
    logic [INSTR_WIDTH-1:0]    wdl [64];
    int nw = 0;
    int nrd = 0;
    int proto_err = 0;

    always @(posedge clk) begin
        if (we_o) begin
            wa[nw]  <= ma_o;
            wdl[nw] <= wd_o;
            nw      <= nw + 1;
        end
        if (rd_o) nrd <= nrd + 1;
    end

    always @(negedge clk) begin
        if ((rd_o && fifo_empty) || (rd_o && we_o)) proto_err <= proto_err + 1;
    end

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [INSTR_WIDTH-1:0] w);
        fbuf[push_cnt] = w;
        push_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        skip_cnt = push_cnt - pop_cnt;
    endtask

    task automatic start(input logic [MEM_ADDR_WIDTH-1:0] a);
        @(posedge clk);
        #1 addr = a;
        do_it = 1'b1;
        @(posedge clk);
        #1 do_it = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (done_o) break;
        end
        chk(tag, 32'(done_o), 32'd1);
    endtask

    int cyc, w0, r0;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_rd", 32'(rd_o), 0);
        chk("rst_mem_we", 32'(we_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_stop", 32'(stop_o), 0);
        chk("rst_addr_out", 32'(ao_o), 0);
        chk("rst_mem_addr", 32'(ma_o), 0);
        chk("rst_mem_wdata", 32'(wd_o), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Full batch of 4 from 0x10, fifth word left behind
        sel = 0;
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444); push(16'h5555);
        w0 = nw;
        start(8'h10);
        wait_done("s1_done_seen", cyc);
        chk("s1_cycles", 32'(cyc), 13);
        chk("s1_addr_out", 32'(ao_o), 32'h14);
        chk("s1_stop", 32'(stop_o), 0);
        chk("s1_nwrites", 32'(nw - w0), 4);
        for (int i = 0; i < 4; i++) begin
            chk("s1_waddr", 32'(wa[w0 + i]), 32'h10 + 32'(i));
            chk("s1_wdata", 32'(wdl[w0 + i]), 32'h1111 * 32'(i + 1));
        end
        chk("s1_fifo_left", 32'(push_cnt - pop_cnt - skip_cnt), 1);
        @(negedge clk);
        chk("s1_done_pulse", 32'(done_o), 0);
        chk("s1_addr_out_held", 32'(ao_o), 32'h14);

        // STOP ends the batch early and locks out later requests
        sel = 1;
        do_reset();
        push(16'hAAAA); push(INSTR_STOP);
        w0 = nw;
        start(8'h40);
        wait_done("s2_done_seen", cyc);
        chk("s2_cycles", 32'(cyc), 7);
        chk("s2_addr_out", 32'(ao_o), 32'h42);
        chk("s2_stop", 32'(stop_o), 1);
        chk("s2_nwrites", 32'(nw - w0), 2);
        chk("s2_waddr0", 32'(wa[w0]), 32'h40);
        chk("s2_wdata0", 32'(wdl[w0]), 32'hAAAA);
        chk("s2_waddr1", 32'(wa[w0 + 1]), 32'h41);
        chk("s2_wdata1", 32'(wdl[w0 + 1]), 32'hFFFF);
        push(16'h7777);
        r0 = nrd;
        @(posedge clk);
        #1 do_it = 1'b1;
        repeat (10) @(negedge clk);
        do_it = 1'b0;
        chk("s2_no_read_after_stop", 32'(nrd), 32'(r0));
        chk("s2_no_write_after_stop", 32'(nw - w0), 2);
        chk("s2_stop_sticky", 32'(stop_o), 1);

        // Memory stall during WRITE, then FIFO starvation in REQ
        sel = 0;
        do_reset();
        push(16'h1234);
        mem_busy = 1'b1;
        w0 = nw;
        start(8'h20);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_busy_no_we", 32'(we_o), 0);
            chk("s3_busy_addr", 32'(ma_o), 32'h20);
            chk("s3_busy_data", 32'(wd_o), 32'h1234);
        end
        @(posedge clk);
        #1 mem_busy = 1'b0;
        @(negedge clk);
        chk("s3_we_release", 32'(we_o), 1);
        chk("s3_we_addr", 32'(ma_o), 32'h20);
        r0 = nrd + 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s4_empty_no_rd", 32'(rd_o), 0);
        end
        chk("s3_one_write", 32'(nw - w0), 1);
        @(posedge clk);
        #1 push(16'h2345);
        @(negedge clk);
        chk("s4_rd_after_push", 32'(rd_o), 1);
        push(16'h3456); push(16'h4567);
        wait_done("s4_done_seen", cyc);
        chk("s4_addr_out", 32'(ao_o), 32'h24);
        chk("s4_nwrites", 32'(nw - w0), 4);
        chk("s4_last_data", 32'(wdl[w0 + 3]), 32'h4567);
        chk("s4_last_addr", 32'(wa[w0 + 3]), 32'h23);

        // Address wrap at the top of memory
        sel = 2;
        do_reset();
        push(16'hA001); push(16'hA002); push(16'hA003);
        w0 = nw;
        start(8'hFE);
        wait_done("s5_done_seen", cyc);
        chk("s5_cycles", 32'(cyc), 10);
        chk("s5_waddr0", 32'(wa[w0]), 32'hFE);
        chk("s5_waddr1", 32'(wa[w0 + 1]), 32'hFF);
        chk("s5_waddr2", 32'(wa[w0 + 2]), 32'h00);
        chk("s5_wdata2", 32'(wdl[w0 + 2]), 32'hA003);
        chk("s5_addr_out", 32'(ao_o), 32'h01);

        // Reset in CAPT abandons the batch; next batch runs cleanly
        sel = 0;
        do_reset();
        push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004);
        w0 = nw;
        r0 = nrd;
        start(8'h30);
        repeat (2) @(negedge clk);
        chk("s6_pre_reset_addr", 32'(ma_o), 32'h30);
        reset = 1'b1;
        #1;
        chk("s6_rst_fifo_rd", 32'(rd_o), 0);
        chk("s6_rst_mem_we", 32'(we_o), 0);
        chk("s6_rst_done", 32'(done_o), 0);
        chk("s6_rst_mem_addr", 32'(ma_o), 0);
        chk("s6_rst_addr_out", 32'(ao_o), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("s6_no_write", 32'(nw - w0), 0);
        chk("s6_one_read", 32'(nrd - r0), 1);
        push(16'hB005);
        start(8'h50);
        wait_done("s6_done_seen", cyc);
        chk("s6_addr_out", 32'(ao_o), 32'h54);
        chk("s6_nwrites", 32'(nw - w0), 4);
        for (int i = 0; i < 4; i++) begin
            chk("s6_waddr", 32'(wa[w0 + i]), 32'h50 + 32'(i));
            chk("s6_wdata", 32'(wdl[w0 + i]), 32'hB002 + 32'(i));
        end

        chk("protocol_errors", 32'(proto_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
